// File: rtl/bus_arb_pkg.sv
// Shared constants and FSM encoding for the four-master bus arbiter.
package bus_arb_pkg;
    localparam int N_MASTERS = 4;
    localparam int N_SLAVES  = 4;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int DEC_HI    = 7;
    localparam int DEC_LO    = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/bus_arbiter4_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping
// back to i_last itself, skipping any master flagged in i_excl.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [N_MASTERS-1:0] i_req,
    input  logic [1:0]           i_last,
    input  logic [N_MASTERS-1:0] i_excl,
    output logic                 o_valid,
    output logic [1:0]           o_idx
);
    logic [N_MASTERS-1:0] w_cand;
    logic [1:0]           w_i;

    assign w_cand = i_req & ~i_excl;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_i     = '0;
        // scan farthest-first so the nearest candidate overwrites last
        for (int k = N_MASTERS; k >= 1; k--) begin
            w_i = i_last + 2'(k);
            if (w_cand[w_i]) begin
                o_valid = 1'b1;
                o_idx   = w_i;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter4.sv
// Four-master / four-slave shared bus: registered round-robin grant with a
// hold limit, address decode to one-hot slave selects, registered read return.
module bus_arbiter4
    import bus_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)(
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          M_req,
    input  logic [N_MASTERS-1:0]          M_wr,
    input  logic [N_MASTERS*ADDR_W-1:0]   M_address,
    input  logic [N_MASTERS*DATA_W-1:0]   M_dout,
    output logic [N_MASTERS-1:0]          M_grant,
    output logic [DATA_W-1:0]             M_din,
    output logic [N_SLAVES-1:0]           S_sel,
    output logic [ADDR_W-1:0]             S_address,
    output logic                          S_wr,
    output logic [DATA_W-1:0]             S_din,
    input  logic [N_SLAVES*DATA_W-1:0]    S_dout,
    output logic [1:0]                    owner,
    output logic                          busy
);
    arb_state_e           r_state;
    logic [N_MASTERS-1:0] r_grant;
    logic [1:0]           r_owner;
    logic [1:0]           r_last;
    logic [7:0]           r_hold_cnt;
    logic [N_SLAVES-1:0]  r_sel_q;

    logic                 w_pick_vld;
    logic [1:0]           w_pick_idx;
    logic [N_MASTERS-1:0] w_excl;
    logic                 w_hold_end;
    logic                 w_own_req;

    // While owned, the current holder is never a hand-over candidate.
    assign w_excl     = (r_state == OWNED) ? r_grant : '0;
    assign w_hold_end = (r_hold_cnt == 8'(MAX_HOLD - 1));
    assign w_own_req  = M_req[r_owner];

    rr_pick u_pick (
        .i_req   (M_req),
        .i_last  (r_last),
        .i_excl  (w_excl),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_owner    <= 2'd0;
            r_last     <= 2'd3;
            r_hold_cnt <= '0;
            r_sel_q    <= '0;
        end else begin
            r_sel_q <= S_sel;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_state    <= OWNED;
                        r_grant    <= 4'b0001 << w_pick_idx;
                        r_owner    <= w_pick_idx;
                        r_last     <= w_pick_idx;
                        r_hold_cnt <= '0;
                    end
                end
                OWNED: begin
                    if (!w_own_req || w_hold_end) begin
                        r_hold_cnt <= '0;
                        if (w_pick_vld) begin
                            r_grant <= 4'b0001 << w_pick_idx;
                            r_owner <= w_pick_idx;
                            r_last  <= w_pick_idx;
                        end else if (!w_own_req) begin
                            r_state <= IDLE;
                            r_grant <= '0;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign M_grant = r_grant;
    assign owner   = r_owner;
    assign busy    = |r_grant;

    always_comb begin
        S_sel     = '0;
        S_address = '0;
        S_wr      = 1'b0;
        S_din     = '0;
        if (busy) begin
            S_address = M_address[r_owner*ADDR_W +: ADDR_W];
            S_wr      = M_wr[r_owner];
            S_din     = M_dout[r_owner*DATA_W +: DATA_W];
            S_sel     = 4'b0001 << S_address[DEC_HI:DEC_LO];
        end
    end

    // Slaves register read data, so return the lane selected last cycle.
    always_comb begin
        M_din = '0;
        for (int j = 0; j < N_SLAVES; j++) begin
            if (r_sel_q[j]) M_din = S_dout[j*DATA_W +: DATA_W];
        end
    end
endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: vector table, directed corner sequences and a
// randomized run against a behavioural arbitration model.
module tb_bus_arbiter4;
    localparam int MH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  M_req, M_wr;
    logic [31:0] M_address, M_dout, S_dout;
    logic [3:0]  M_grant, S_sel;
    logic [7:0]  M_din, S_address, S_din;
    logic        S_wr, busy;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_err    = 0;

    bus_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk(clk), .reset(reset), .M_req(M_req), .M_wr(M_wr),
        .M_address(M_address), .M_dout(M_dout), .M_grant(M_grant),
        .M_din(M_din), .S_sel(S_sel), .S_address(S_address), .S_wr(S_wr),
        .S_din(S_din), .S_dout(S_dout), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Round-robin search from last+1 around to last, skipping excl (-1: none).
    function automatic int rr(input logic [3:0] req, input int last, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int m;
            m = (last + k) % 4;
            if (req[m] && m != excl) return m;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] own;
        logic       bsy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n_hold;
        int own_m, last_m, hold_m, selq_m, esel, p;
        logic [7:0] ea;

        tbl[0] = '{4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[1] = '{4'b1110, 4'b0010, 2'd1, 1'b1};
        tbl[2] = '{4'b1100, 4'b0100, 2'd2, 1'b1};
        tbl[3] = '{4'b1000, 4'b1000, 2'd3, 1'b1};
        tbl[4] = '{4'b0000, 4'b0000, 2'd3, 1'b0};
        tbl[5] = '{4'b0011, 4'b0001, 2'd0, 1'b1};
        tbl[6] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
        tbl[7] = '{4'b0110, 4'b0010, 2'd1, 1'b1};
        tbl[8] = '{4'b0100, 4'b0100, 2'd2, 1'b1};
        tbl[9] = '{4'b0000, 4'b0000, 2'd2, 1'b0};

        reset = 1'b1; M_req = 4'b1111; M_wr = '0;
        M_address = '0; M_dout = '0; S_dout = 32'hA5A5A5A5;
        step; step;
        chk("rst_grant", M_grant, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sel", S_sel, 0);
        chk("rst_mdin", M_din, 0);
        chk("rst_hold", dut.r_hold_cnt, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            M_req = tbl[i].req;
            step;
            chk($sformatf("tbl%0d_grant", i), M_grant, tbl[i].grant);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
            if (tbl[i].bsy) chk($sformatf("tbl%0d_owner", i), owner, tbl[i].own);
        end

        // master 1 alone: continuous grant, hold counter wraps 0..MH-1
        M_req = 4'b0010;
        step;
        for (int i = 0; i < 40; i++) begin
            chk("solo_grant", M_grant, 4'b0010);
            chk("solo_hold", dut.r_hold_cnt, i % MH);
            step;
        end
        M_req = 4'b0000;
        step;

        // master 0 holds, master 2 joins: preemption after MH grant cycles
        M_req = 4'b0001;
        step;
        n_hold = 1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) M_req = 4'b0101;
            step;
            if (M_grant == 4'b0001) n_hold++;
            else break;
        end
        chk("preempt_len", n_hold, MH);
        chk("preempt_grant", M_grant, 4'b0100);
        M_req = 4'b0000;
        step;

        // master 3 writes to the timer, then reads it back
        M_req = 4'b1000;
        step;
        chk("m3_grant", M_grant, 4'b1000);
        M_wr = 4'b1000; M_address = 32'h41000000; M_dout = 32'h5A000000;
        #1;
        chk("wr_sel", S_sel, 4'b0010);
        chk("wr_addr", S_address, 8'h41);
        chk("wr_wr", S_wr, 1);
        chk("wr_din", S_din, 8'h5A);
        step;
        M_wr = 4'b0000;
        #1;
        chk("rd_wr", S_wr, 0);
        step;
        S_dout = 32'hEEDDC3BB;
        #1;
        chk("rd_mdin", M_din, 8'hC3);

        // reset in the middle of a write
        M_wr = 4'b1000;
        reset = 1'b1;
        step;
        chk("mid_rst_grant", M_grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sel", S_sel, 0);
        chk("mid_rst_swr", S_wr, 0);
        chk("mid_rst_din", S_din, 0);
        chk("mid_rst_addr", S_address, 0);
        chk("mid_rst_mdin", M_din, 0);
        chk("mid_rst_state", int'(dut.r_state), 0);
        reset = 1'b0;
        M_req = '0; M_wr = '0;
        step;

        // randomized traffic against a behavioural model
        reset = 1'b1;
        step;
        reset = 1'b0;
        own_m = -1; last_m = 3; hold_m = 0; selq_m = -1;
        for (int c = 0; c < 600; c++) begin
            logic [3:0] nr;
            nr = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (own_m >= 0 && $urandom_range(0, 7) != 0) nr[own_m] = 1'b1;
            M_req = nr; M_wr = 4'($urandom);
            M_address = $urandom; M_dout = $urandom; S_dout = $urandom;
            #1;
            chk("rnd_grant", M_grant, own_m >= 0 ? (1 << own_m) : 0);
            chk("rnd_busy", busy, own_m >= 0);
            chk("rnd_mdin", M_din, selq_m >= 0 ? S_dout[selq_m*8 +: 8] : 0);
            if (own_m >= 0) begin
                ea = M_address[own_m*8 +: 8];
                esel = ea / 64;
                chk("rnd_owner", owner, own_m);
                chk("rnd_addr", S_address, ea);
                chk("rnd_swr", S_wr, M_wr[own_m]);
                chk("rnd_sdin", S_din, M_dout[own_m*8 +: 8]);
                chk("rnd_sel", S_sel, 1 << esel);
            end else begin
                esel = -1;
                chk("rnd_sel_idle", S_sel, 0);
            end
            selq_m = esel;
            if (own_m < 0) begin
                p = rr(nr, last_m, -1);
                if (p >= 0) begin own_m = p; last_m = p; hold_m = 0; end
            end else if (!nr[own_m] || hold_m == MH - 1) begin
                p = rr(nr, last_m, own_m);
                if (p >= 0) begin own_m = p; last_m = p; end
                else if (!nr[own_m]) own_m = -1;
                hold_m = 0;
            end else begin
                hold_m++;
            end
            step;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
